// File: rtl/tpu_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the TPU slave port.
//
// Handshake: mK_req is the valid and mK_gnt the ready of requester K. A
// transfer happens in any cycle where both are high. The requester holds
// req, we, addr and wdata stable until it is granted. axi_req is a one-cycle
// command pulse that the TPU always accepts. Read data returns on mK_rvalid,
// a one-cycle pulse with no ready.
interface tpu_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              axi_req;
  logic              axi_we;
  logic [ADDR_W-1:0] axi_addr;
  logic [DATA_W-1:0] axi_wdata;
  logic [DATA_W-1:0] axi_rdata;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output axi_req, axi_we, axi_addr, axi_wdata,
    input  axi_rdata
  );

  // Environment view: both requesters plus the TPU slave.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  axi_req, axi_we, axi_addr, axi_wdata,
    output axi_rdata
  );
endinterface

// File: rtl/tpu_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the TPU slave port.
// The grant is combinational. The winning request is registered onto the
// axi_* bus one cycle later. A {valid, id} shift pipe follows each read so
// that axi_rdata is steered back to the requester that issued it.
module tpu_bus_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  tpu_bus_arbiter_if.slave   bus
);
  localparam int DEPTH = READ_LAT + 1;

  // Priority pointer: 0 favours m0, 1 favours m1.
  logic              ptr;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Slot k holds the read issued on axi_req k cycles ago; id 1 means m1.
  logic [DEPTH-1:0]  pipe_vld;
  logic [DEPTH-1:0]  pipe_id;

  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Grant selection and request mux. The fields are zero when nothing is granted.
  always_comb begin
    gnt0      = bus.m0_req && (!bus.m1_req || (ptr == 1'b0));
    gnt1      = bus.m1_req && (!bus.m0_req || (ptr == 1'b1));
    xfer      = gnt0 || gnt1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = bus.m0_we;
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
    end else if (gnt1) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  // Round-robin pointer: after a transfer, priority passes to the other requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  // Issue register: one axi_req cycle per transfer, bus fields zero when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= xfer;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Read-tracking pipe. Slot 0 lines up with the axi_req cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld <= {pipe_vld[DEPTH-2:0], xfer && !sel_we};
      pipe_id  <= {pipe_id[DEPTH-2:0], gnt1};
    end
  end

  // Return path. Capture axi_rdata as the matured slot leaves the pipe and steer it by id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= pipe_vld[READ_LAT] && !pipe_id[READ_LAT];
      rvalid1_q <= pipe_vld[READ_LAT] && pipe_id[READ_LAT];
      if (pipe_vld[READ_LAT] && !pipe_id[READ_LAT]) begin
        rdata0_q <= bus.axi_rdata;
      end
      if (pipe_vld[READ_LAT] && pipe_id[READ_LAT]) begin
        rdata1_q <= bus.axi_rdata;
      end
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.axi_req   = req_q;
  assign bus.axi_we    = we_q;
  assign bus.axi_addr  = addr_q;
  assign bus.axi_wdata = wdata_q;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_tpu_bus_arbiter.sv
// Directed bench for tpu_bus_arbiter. dut1 uses READ_LAT=1 and dut3 uses
// READ_LAT=3. A small TPU model answers reads at the configured latency and
// drives a poison value on axi_rdata in every other cycle.
module tb_tpu_bus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [DW-1:0] POISON = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  tpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  tpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  tpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  tpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // TPU model: fixed contents for the tested addresses, data valid only in cycle t1+READ_LAT.
  function automatic logic [DW-1:0] tpu_word(input logic [AW-1:0] a);
    case (a)
      64'h0000_0000_4001_7008: return 64'h1;
      64'h0000_0000_4000_0000: return 64'hAAAA;
      64'h0000_0000_4000_0008: return 64'hBBBB;
      default:                 return a ^ 64'h5A5A;
    endcase
  endfunction

  logic [3:0]    rq1_v = '0;
  logic [3:0]    rq3_v = '0;
  logic [AW-1:0] rq1_a [4];
  logic [AW-1:0] rq3_a [4];

  always @(posedge clk) begin
    rq1_v    <= {rq1_v[2:0], bus1.axi_req && !bus1.axi_we};
    rq3_v    <= {rq3_v[2:0], bus3.axi_req && !bus3.axi_we};
    rq1_a[0] <= bus1.axi_addr;
    rq3_a[0] <= bus3.axi_addr;
    for (int i = 1; i < 4; i++) begin
      rq1_a[i] <= rq1_a[i-1];
      rq3_a[i] <= rq3_a[i-1];
    end
  end

  assign bus1.axi_rdata = rq1_v[0] ? tpu_word(rq1_a[0]) : POISON;
  assign bus3.axi_rdata = rq3_v[2] ? tpu_word(rq3_a[2]) : POISON;

  // Driver: put every requester input of both buses to idle
  task automatic idle_all();
    bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
    bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = '0; bus1.m1_wdata = '0;
    bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
    bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0;
  endtask

  // Reset held with m0 requesting, then the first grant and issue after release
  task automatic test_reset();
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b1;
    bus1.m0_addr = 64'h4000_0010; bus1.m0_wdata = 64'h55;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus1.axi_req, bus1.axi_we, bus1.m0_rvalid, bus1.m1_rvalid, bus3.axi_req} !== 5'b0) begin
        n_fail++; $display("FAIL rst_ctrl: got %b required 00000",
          {bus1.axi_req, bus1.axi_we, bus1.m0_rvalid, bus1.m1_rvalid, bus3.axi_req});
      end
      n_run++;
      if (bus1.axi_addr !== 64'h0 || bus1.axi_wdata !== 64'h0 || bus1.m0_rdata !== 64'h0) begin
        n_fail++; $display("FAIL rst_data: got addr=%0h wdata=%0h rdata=%0h required 0",
          bus1.axi_addr, bus1.axi_wdata, bus1.m0_rdata);
      end
      n_run++;
      if (bus1.m0_gnt !== 1'b1) begin
        n_fail++; $display("FAIL rst_gnt: got %b required 1", bus1.m0_gnt);
      end
    end
    rst = 1'b1;
    #1;
    n_run++;
    if (bus1.m0_gnt !== 1'b1 || bus1.m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL first_gnt: got %b%b required 10", bus1.m0_gnt, bus1.m1_gnt);
    end
    @(negedge clk);
    bus1.m0_req = 1'b0;
    n_run++;
    if (bus1.axi_req !== 1'b1 || bus1.axi_we !== 1'b1 || bus1.axi_addr !== 64'h4000_0010 ||
        bus1.axi_wdata !== 64'h55) begin
      n_fail++; $display("FAIL first_issue: got req=%b we=%b addr=%0h wdata=%0h required 1 1 40000010 55",
        bus1.axi_req, bus1.axi_we, bus1.axi_addr, bus1.axi_wdata);
    end
    @(negedge clk);
    n_run++;
    if (bus1.axi_req !== 1'b0 || bus1.axi_addr !== 64'h0 || bus1.axi_wdata !== 64'h0) begin
      n_fail++; $display("FAIL idle_after_issue: got req=%b addr=%0h wdata=%0h required 0 0 0",
        bus1.axi_req, bus1.axi_addr, bus1.axi_wdata);
    end
  endtask

  // m1 writes alone: one issue cycle, no read return
  task automatic test_write_m1();
    @(negedge clk);
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b1;
    bus1.m1_addr = 64'h4001_7000; bus1.m1_wdata = 64'h1;
    #1;
    n_run++;
    if (bus1.m1_gnt !== 1'b1 || bus1.m0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL wr_gnt: got m0=%b m1=%b required 0 1", bus1.m0_gnt, bus1.m1_gnt);
    end
    @(negedge clk);
    bus1.m1_req = 1'b0;
    bus1.m1_addr = 64'h4001_7FF8; bus1.m1_wdata = 64'hFF;
    n_run++;
    if (bus1.axi_req !== 1'b1 || bus1.axi_we !== 1'b1 || bus1.axi_addr !== 64'h4001_7000 ||
        bus1.axi_wdata !== 64'h1) begin
      n_fail++; $display("FAIL wr_issue: got req=%b we=%b addr=%0h wdata=%0h required 1 1 40017000 1",
        bus1.axi_req, bus1.axi_we, bus1.axi_addr, bus1.axi_wdata);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_run++;
      if (bus1.axi_req !== 1'b0 || bus1.m0_rvalid !== 1'b0 || bus1.m1_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL wr_quiet[%0d]: got req=%b rv0=%b rv1=%b required 0 0 0",
          k, bus1.axi_req, bus1.m0_rvalid, bus1.m1_rvalid);
      end
    end
  endtask

  // Both requesters hold write requests for six cycles: grants alternate, issues back to back
  task automatic test_round_robin();
    logic exp0;
    @(negedge clk);
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b1; bus1.m0_addr = 64'h4000_0100; bus1.m0_wdata = 64'h100;
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b1; bus1.m1_addr = 64'h4000_0200; bus1.m1_wdata = 64'h200;
    for (int c = 0; c < 6; c++) begin
      exp0 = (c % 2 == 0);
      #1;
      n_run++;
      if (bus1.m0_gnt !== exp0 || bus1.m1_gnt !== !exp0) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b required %b%b",
          c, bus1.m0_gnt, bus1.m1_gnt, exp0, !exp0);
      end
      @(negedge clk);
      n_run++;
      if (bus1.axi_req !== 1'b1 || bus1.axi_addr !== (exp0 ? 64'h4000_0100 : 64'h4000_0200) ||
          bus1.axi_wdata !== (exp0 ? 64'h100 : 64'h200)) begin
        n_fail++; $display("FAIL rr_issue[%0d]: got req=%b addr=%0h wdata=%0h required 1 %0h %0h",
          c, bus1.axi_req, bus1.axi_addr, bus1.axi_wdata,
          exp0 ? 64'h4000_0100 : 64'h4000_0200, exp0 ? 64'h100 : 64'h200);
      end
    end
    bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus1.axi_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_end: got req=%b required 0", bus1.axi_req);
    end
  endtask

  // m1 reads alone: rvalid three cycles after the grant, rdata then holds
  task automatic test_read_m1();
    @(negedge clk);
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 64'h4001_7008;
    #1;
    n_run++;
    if (bus1.m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rd_gnt: got %b required 1", bus1.m1_gnt);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus1.m1_req = 1'b0;
        bus1.m1_addr = 64'h4000_0008;
      end
      n_run++;
      if (bus1.m1_rvalid !== (k == 3) || bus1.m0_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL rd_rvalid[%0d]: got rv0=%b rv1=%b required 0 %b",
          k, bus1.m0_rvalid, bus1.m1_rvalid, (k == 3));
      end
      if (k >= 3) begin
        n_run++;
        if (bus1.m1_rdata !== 64'h1) begin
          n_fail++; $display("FAIL rd_data[%0d]: got %0h required 1", k, bus1.m1_rdata);
        end
      end
    end
  endtask

  // Consecutive reads by m0 then m1 at READ_LAT=1: returns in consecutive cycles to the right owners
  task automatic test_back_to_back();
    @(negedge clk);
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 64'h4000_0000;
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 64'h4000_0008;
    #1;
    n_run++;
    if (bus1.m0_gnt !== 1'b1 || bus1.m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gnt0: got %b%b required 10", bus1.m0_gnt, bus1.m1_gnt);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus1.m0_req = 1'b0;
        #1;
        n_run++;
        if (bus1.m1_gnt !== 1'b1 || bus1.m0_gnt !== 1'b0) begin
          n_fail++; $display("FAIL b2b_gnt1: got %b%b required 01", bus1.m0_gnt, bus1.m1_gnt);
        end
      end
      if (k == 2) bus1.m1_req = 1'b0;
      n_run++;
      if (bus1.m0_rvalid !== (k == 3) || bus1.m1_rvalid !== (k == 4)) begin
        n_fail++; $display("FAIL b2b_rvalid[%0d]: got rv0=%b rv1=%b required %b %b",
          k, bus1.m0_rvalid, bus1.m1_rvalid, (k == 3), (k == 4));
      end
      if (k == 3) begin
        n_run++;
        if (bus1.m0_rdata !== 64'hAAAA) begin
          n_fail++; $display("FAIL b2b_data0: got %0h required aaaa", bus1.m0_rdata);
        end
      end
      if (k == 4) begin
        n_run++;
        if (bus1.m1_rdata !== 64'hBBBB) begin
          n_fail++; $display("FAIL b2b_data1: got %0h required bbbb", bus1.m1_rdata);
        end
      end
    end
  endtask

  // Same read pair at READ_LAT=3: each return two cycles later
  task automatic test_back_to_back_lat3();
    @(negedge clk);
    bus3.m0_req = 1'b1; bus3.m0_we = 1'b0; bus3.m0_addr = 64'h4000_0000;
    bus3.m1_req = 1'b1; bus3.m1_we = 1'b0; bus3.m1_addr = 64'h4000_0008;
    #1;
    n_run++;
    if (bus3.m0_gnt !== 1'b1 || bus3.m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL l3_gnt0: got %b%b required 10", bus3.m0_gnt, bus3.m1_gnt);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus3.m0_req = 1'b0;
        #1;
        n_run++;
        if (bus3.m1_gnt !== 1'b1) begin
          n_fail++; $display("FAIL l3_gnt1: got %b required 1", bus3.m1_gnt);
        end
      end
      if (k == 2) bus3.m1_req = 1'b0;
      n_run++;
      if (bus3.m0_rvalid !== (k == 5) || bus3.m1_rvalid !== (k == 6)) begin
        n_fail++; $display("FAIL l3_rvalid[%0d]: got rv0=%b rv1=%b required %b %b",
          k, bus3.m0_rvalid, bus3.m1_rvalid, (k == 5), (k == 6));
      end
      if (k == 5) begin
        n_run++;
        if (bus3.m0_rdata !== 64'hAAAA) begin
          n_fail++; $display("FAIL l3_data0: got %0h required aaaa", bus3.m0_rdata);
        end
      end
      if (k == 6) begin
        n_run++;
        if (bus3.m1_rdata !== 64'hBBBB) begin
          n_fail++; $display("FAIL l3_data1: got %0h required bbbb", bus3.m1_rdata);
        end
      end
    end
  endtask

  // Reset while a read is in flight: it never returns, and priority restarts at m0
  task automatic test_reset_flush();
    @(negedge clk);
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 64'h4000_0000;
    #1;
    n_run++;
    if (bus1.m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL fl_gnt: got %b required 1", bus1.m0_gnt);
    end
    @(negedge clk);
    bus1.m0_req = 1'b0;
    rst = 1'b0;
    #1;
    n_run++;
    if (bus1.axi_req !== 1'b0) begin
      n_fail++; $display("FAIL fl_async: got req=%b required 0", bus1.axi_req);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      n_run++;
      if (bus1.m0_rvalid !== 1'b0 || bus1.m1_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL fl_rvalid[%0d]: got rv0=%b rv1=%b required 0 0",
          k, bus1.m0_rvalid, bus1.m1_rvalid);
      end
      @(negedge clk);
    end
    bus1.m0_req = 1'b1; bus1.m0_we = 1'b1; bus1.m0_addr = 64'h4000_0300; bus1.m0_wdata = 64'h3;
    bus1.m1_req = 1'b1; bus1.m1_we = 1'b1; bus1.m1_addr = 64'h4000_0400; bus1.m1_wdata = 64'h4;
    #1;
    n_run++;
    if (bus1.m0_gnt !== 1'b1 || bus1.m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fl_ptr: got %b%b required 10", bus1.m0_gnt, bus1.m1_gnt);
    end
    @(negedge clk);
    bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
    n_run++;
    if (bus1.axi_req !== 1'b1 || bus1.axi_addr !== 64'h4000_0300) begin
      n_fail++; $display("FAIL fl_issue: got req=%b addr=%0h required 1 40000300",
        bus1.axi_req, bus1.axi_addr);
    end
    @(negedge clk);
  endtask

  // Test sequence and final report
  initial begin
    idle_all();
    test_reset();
    test_write_m1();
    test_round_robin();
    test_read_m1();
    test_back_to_back();
    test_back_to_back_lat3();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_bus_arbiter.md
Name: tpu_bus_arbiter

Overview:
- Two-requester arbiter in front of the `tpu` AXI-style slave port (axi_req/axi_we/axi_addr/axi_wdata/axi_rdata).
- Lets a host-side master (m0, e.g. CPU bridge) and a local sequencer (m1, e.g. enable/poll/readback engine) share the single TPU bus.
- Round-robin grant; one request issued per cycle; downstream request registered.
- Tracks in-flight reads and routes axi_rdata back to the issuing requester.

Parameters:
- ADDR_W, 64, address width (m*_addr, axi_addr).
- DATA_W, 64, data width (wdata/rdata).
- READ_LAT, 1, cycles from the axi_req-high cycle to the cycle axi_rdata is valid (1..4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 request; held until granted.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  ADDR_W  byte address (TPU word index << 3 + 0x4000_0000).
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  combinational grant; transfer occurs when m0_req && m0_gnt.
- m0_rvalid  out  1  one-cycle pulse, read data for m0.
- m0_rdata  out  DATA_W  read data, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester 1.
- axi_req  out  1  single-cycle request to TPU.
- axi_we  out  1  write enable to TPU.
- axi_addr  out  ADDR_W  address to TPU.
- axi_wdata  out  DATA_W  write data to TPU.
- axi_rdata  in  DATA_W  TPU read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - axi_req=0, axi_we=0, axi_addr=0, axi_wdata=0.
  - m*_rvalid=0, m*_rdata=0.
  - Priority pointer reset to m0.
  - Read-tracking pipe cleared.
  - m*_gnt still follows the combinational rule below, using pointer=m0.
- Grant, evaluated each cycle:
  - Only one requester asserting req: that requester is granted.
  - Both asserting: the one indicated by the priority pointer is granted.
  - At most one gnt high per cycle. gnt never asserts without the matching req.
- Pointer update:
  - After a transfer by mK, the pointer moves to the other requester.
  - No transfer: pointer unchanged.
- Issue:
  - A transfer in cycle t drives axi_req=1 with the captured we/addr/wdata in cycle t+1, for exactly one cycle.
  - With no transfer, axi_req=0 and axi_we/axi_addr/axi_wdata return to 0.
  - Back-to-back transfers produce back-to-back axi_req cycles; no idle bubble is required.
- Read tracking:
  - Shift pipe of depth READ_LAT+1 carrying {valid, id}, loaded at issue with valid = transfer && !we.
  - When the entry for axi_req cycle t1 matures, axi_rdata is sampled at the end of cycle t1+READ_LAT.
  - The owning mK_rvalid=1 and mK_rdata=sampled value are driven in cycle t1+READ_LAT+1.
  - The other requester's rvalid stays 0. m*_rdata holds its last value when rvalid=0.
  - Total read latency, grant cycle to rvalid: READ_LAT+2 cycles (3 at default).
- Writes produce no rvalid.
- Read/write interleave: any order is allowed.
  - The pipe keeps per-slot ids, so returns stay in issue order and are never misrouted.
  - Two consecutive reads from different requesters return in consecutive cycles, to the correct owners.
- Requester inputs are sampled only in the grant cycle; later changes do not affect an issued transfer.
- Reset mid-operation: all in-flight reads are discarded. No rvalid is produced for them after rst deasserts.
- No backpressure from the TPU. The slave accepts every axi_req.

Test Plan:
1. Reset with rst=0 for 5 cycles while m0_req=1: all axi_* outputs and m*_rvalid stay 0. After release, m0_gnt=1 and the first axi_req appears one cycle after the grant cycle.
2. m1 writes 0x1 to 0x4001_7000 with m0 idle: m1_gnt=1 in cycle t; axi_req=1, axi_we=1, axi_addr=0x4001_7000, axi_wdata=0x1 in t+1; no rvalid.
3. Both requesters hold req for 6 cycles: grants alternate m0,m1,m0,m1,m0,m1, and axi_req is high for 6 consecutive cycles.
4. m1 reads 0x4001_7008 while the TPU model returns 0x1 at READ_LAT=1: m1_rvalid=1 with m1_rdata=0x1 exactly 3 cycles after the grant; m0_rvalid stays 0.
5. m0 reads 0x4000_0000 (model returns 0xAAAA) and m1 reads 0x4000_0008 (model returns 0xBBBB) in consecutive cycles: m0_rvalid/0xAAAA, then m1_rvalid/0xBBBB in the next cycle. Repeat with READ_LAT=3: same order, with each return 2 cycles later.
6. Issue a read, then assert rst for 1 cycle before its return: no m*_rvalid is ever produced for that read, and the next transfer after reset is granted to m0 first.
